miller_decoder: RTL and testbench
=================================

MILLER_DECODER -- requirements
Module: miller_decoder

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 8'hD3: byte pattern that opens a frame.
REQ-002 SHALL have parameter FRAME_LEN, default 16: payload bytes per frame, range 1..255.
REQ-003 SHALL have port clk2x, input, 1 bit: half-bit-rate clock; one line sample per rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: decoder run; low means synchronous clear.
REQ-006 SHALL have port din, input, 1 bit: Miller-coded line level from the upstream encoder.
REQ-007 SHALL have port data_out, output, 8 bits: decoded payload byte, MSB received first.
REQ-008 SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-009 SHALL have port data_ready, input, 1 bit: consumer accepts the byte when data_valid and data_ready are both high.
REQ-010 SHALL have port sync_ok, output, 1 bit: high while in state DATA.
REQ-011 SHALL have port code_err, output, 1 bit: one-cycle pulse on a code violation in DATA.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag; a byte was dropped.

Function
REQ-013 SHALL sample din on every clk2x edge while enable=1; a phase bit ph alternates 0 (first half, h0) and 1 (second half, h1).
REQ-014 SHALL keep prev, the h1 sample of the previous bit; prev is 0 after reset and after clear.
REQ-015 SHALL evaluate each bit at the ph=1 edge, with ts = h0^prev, tm = din^h0, bit = tm, prev <= din.
REQ-016 SHALL flag a code violation when ts==tm, meaning zero transitions or two transitions in one bit period.
REQ-017 SHALL implement states HUNT, DATA; reset state HUNT.
REQ-018 In HUNT, SHALL shift each bit into an 8-bit register, MSB-first.
REQ-019 In HUNT, the edge whose bit makes the register equal SYNC_WORD SHALL move the state to DATA and clear the bit and byte counters.
REQ-020 In HUNT, a violation SHALL trigger a phase slip: prev <= h0, h0 <= din, ph <= 1, and no bit is shifted in.
REQ-021 In DATA, SHALL assemble bytes with a 3-bit bit counter.
REQ-022 In DATA, on the 8th bit edge: if data_valid=0 or data_ready=1, SHALL load data_out and set data_valid on that edge; otherwise SHALL drop the byte and set overrun.
REQ-023 SHALL clear data_valid on the edge where data_valid & data_ready=1, unless a new byte loads on the same edge; in that case data_valid stays 1.
REQ-024 In DATA, SHALL count bytes, delivered or dropped; after the FRAME_LEN-th byte the state SHALL return to HUNT, shift register cleared, and no sync_ok glitch.
REQ-025 In DATA, a violation SHALL pulse code_err for one cycle, return to HUNT, and discard the partial byte; data_valid and data_out SHALL be unaffected.
REQ-026 Latency: data_valid SHALL be visible one clk2x cycle after the edge sampling h1 of the byte's 8th bit.
REQ-027 enable=0 SHALL synchronously force state HUNT, ph=0, prev=0, counters and shift register 0, data_valid=0, overrun=0; code_err SHALL stay low.
REQ-028 data_out SHALL hold its value while data_valid=1 and data_ready=0.

Reset
REQ-029 rst=1 SHALL asynchronously set: state HUNT, ph=0, prev=0, shift register 0, counters 0, data_out=8'h00, data_valid=0, sync_ok=0, code_err=0, overrun=0.
REQ-030 rst asserted mid-byte or mid-frame SHALL discard all partial data; decoding SHALL restart at ph=0 on the first edge after release.

Verification
REQ-031 Encoder loopback, both reset together, bits D3 then 8'hA5 x16, data_ready=1 -> sync_ok rises after the 8th bit; 16 bytes of A5 with one data_valid pulse each; then HUNT.
REQ-032 Line stream offset by one clk2x sample -> phase slips in HUNT; after sync, payload 8'h3C decoded correctly and code_err stays 0.
REQ-033 In DATA, force din constant for 2 samples, no transition in one bit -> code_err pulses once, sync_ok falls, held data_out is unchanged.
REQ-034 data_ready=0 through two payload bytes 11, 22 -> data_out=11 held, overrun=1, 22 dropped; frame byte count still advances.
REQ-035 Simultaneous accept and new byte, data_ready=1 on the load edge -> data_valid stays 1 and data_out updates to the new byte.
REQ-036 rst pulse mid-payload, then enable=0 pulse -> all outputs at reset values; the next SYNC_WORD re-locks.

Source files
------------

// File: rtl/miller_decoder.sv
// Miller line decoder: two samples per bit on clk2x, hunts for a sync byte,
// then delivers FRAME_LEN payload bytes through a valid/ready output register.
module miller_decoder #(
    parameter logic [7:0] SYNC_WORD = 8'hD3,
    parameter int         FRAME_LEN = 16
) (
    input  logic       clk2x,
    input  logic       rst,
    input  logic       enable,
    input  logic       din,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       sync_ok,
    output logic       code_err,
    output logic       overrun
);
    typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic       ph_reg, h0_reg, prev_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] byte_cnt_reg;

    logic       ts, tm, viol, bit_edge, sync_hit, byte_done, frame_done;
    logic [7:0] shift_in;

    // ts: transition at bit start, tm: transition mid-bit; a legal bit has exactly one.
    always_comb begin
        ts         = h0_reg ^ prev_reg;
        tm         = din ^ h0_reg;
        viol       = (ts == tm);
        bit_edge   = enable & ph_reg;
        shift_in   = {shift_reg[6:0], tm};
        sync_hit   = (state_reg == HUNT) && !viol && (shift_in == SYNC_WORD);
        byte_done  = (state_reg == DATA) && !viol && (bit_cnt_reg == 3'd7);
        frame_done = byte_done && (byte_cnt_reg == 8'(FRAME_LEN - 1));
    end

    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = HUNT;
        end else if (bit_edge) begin
            case (state_reg)
                HUNT:    if (sync_hit) state_next = DATA;
                DATA:    if (viol || frame_done) state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        sync_ok = (state_reg == DATA);
    end

    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            ph_reg       <= 1'b0;
            h0_reg       <= 1'b0;
            prev_reg     <= 1'b0;
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 8'd0;
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            code_err     <= 1'b0;
            overrun      <= 1'b0;
        end else if (!enable) begin
            ph_reg       <= 1'b0;
            prev_reg     <= 1'b0;
            shift_reg    <= 8'h00;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 8'd0;
            data_valid   <= 1'b0;
            code_err     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            code_err <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (!ph_reg) begin
                h0_reg <= din;
                ph_reg <= 1'b1;
            end else if (state_reg == HUNT && viol) begin
                // Slip by one sample: this sample becomes the first half of a bit.
                prev_reg <= h0_reg;
                h0_reg   <= din;
                ph_reg   <= 1'b1;
            end else begin
                ph_reg   <= 1'b0;
                prev_reg <= din;
                if (state_reg == HUNT) begin
                    shift_reg <= shift_in;
                    if (sync_hit) begin
                        bit_cnt_reg  <= 3'd0;
                        byte_cnt_reg <= 8'd0;
                    end
                end else if (viol) begin
                    code_err    <= 1'b1;
                    shift_reg   <= 8'h00;
                    bit_cnt_reg <= 3'd0;
                end else begin
                    shift_reg   <= shift_in;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (byte_done) begin
                        byte_cnt_reg <= byte_cnt_reg + 8'd1;
                        if (!data_valid || data_ready) begin
                            data_out   <= shift_in;
                            data_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        if (frame_done) begin
                            shift_reg    <= 8'h00;
                            byte_cnt_reg <= 8'd0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_miller_decoder.sv
// Bench for miller_decoder: line encoder, frame-level reference model and
// directed scenarios for sync, phase slip, code violation, overrun and reset.
module tb_miller_decoder;
    localparam logic [7:0] SYNC = 8'hD3;
    localparam int         FLEN = 16;

    typedef logic       bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic       clk2x = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       din = 1'b0;
    logic       data_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, sync_ok, code_err, overrun;

    int     checks = 0;
    int     errors = 0;
    int     err_pulses = 0;
    int     dv_rises = 0;
    logic   dv_d = 1'b0;
    logic   lvl = 1'b0;
    byteq_t acc_q;
    bitq_t  sent;

    miller_decoder #(.SYNC_WORD(SYNC), .FRAME_LEN(FLEN)) dut (
        .clk2x(clk2x), .rst(rst), .enable(enable), .din(din),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .sync_ok(sync_ok), .code_err(code_err), .overrun(overrun)
    );

    always #5 clk2x = ~clk2x;

    // Inputs change 1 time unit after rising edges, so the falling edge sees
    // exactly what the next rising edge will act on.
    always @(negedge clk2x) begin
        if (!rst && enable && data_valid && data_ready) acc_q.push_back(data_out);
        if (code_err) err_pulses <= err_pulses + 1;
        if (data_valid && !dv_d) dv_rises <= dv_rises + 1;
        dv_d <= data_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v);
        din = v;
        @(posedge clk2x);
        #1;
    endtask

    // Exactly one transition per bit: mid-bit for a 1, at the bit start for a 0.
    task automatic send_bit(input logic b);
        sent.push_back(b);
        if (b) begin
            put(lvl); lvl = ~lvl; put(lvl);
        end else begin
            lvl = ~lvl; put(lvl); put(lvl);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic clear();
        enable = 1'b0;
        put(1'b0);
        enable = 1'b1;
        lvl = 1'b0;
        acc_q.delete();
        sent.delete();
    endtask

    // Frame-level model: scan bits for the sync byte, then cut FLEN bytes.
    function automatic byteq_t ref_frames(input bitq_t b);
        byteq_t     r;
        logic [7:0] w, v;
        int         i;
        w = 8'h00;
        i = 0;
        while (i < b.size()) begin
            w = {w[6:0], b[i]};
            i++;
            if (w == SYNC) begin
                for (int k = 0; k < FLEN && i + 8 <= b.size(); k++) begin
                    v = 8'h00;
                    for (int j = 0; j < 8; j++) begin
                        v = {v[6:0], b[i]};
                        i++;
                    end
                    r.push_back(v);
                end
                w = 8'h00;
            end
        end
        return r;
    endfunction

    function automatic logic same_q(input byteq_t a, input byteq_t b);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cmp_frames(input string tag, input byteq_t exp);
        check({tag, "_count"}, acc_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), acc_q[i], exp[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, data_out, 8'h00);
        check({tag, "_data_valid"}, data_valid, 1'b0);
        check({tag, "_sync_ok"}, sync_ok, 1'b0);
        check({tag, "_code_err"}, code_err, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        byteq_t     pay, exp;
        bitq_t      plan;
        int         n;
        logic [7:0] v;

        repeat (3) @(posedge clk2x);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Loopback: sync then 16 x A5 with the consumer always ready.
        dv_rises = 0;
        for (int i = 7; i >= 1; i--) send_bit(SYNC[i]);
        check("sync_before_8th", sync_ok, 1'b0);
        send_bit(SYNC[0]);
        check("sync_after_8th", sync_ok, 1'b1);
        for (int k = 0; k < FLEN - 1; k++) send_byte(8'hA5);
        check("sync_before_last", sync_ok, 1'b1);
        send_byte(8'hA5);
        check("hunt_after_frame", sync_ok, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        exp.delete();
        for (int k = 0; k < FLEN; k++) exp.push_back(8'hA5);
        cmp_frames("loopback", exp);
        check("loopback_pulses", dv_rises, FLEN);

        // Random preambles and payloads against the frame model.
        for (int r = 0; r < 3; r++) begin
            do begin
                plan.delete();
                pay.delete();
                n = $urandom_range(0, 20);
                for (int i = 0; i < n; i++) plan.push_back(1'($urandom_range(0, 1)));
                for (int i = 7; i >= 0; i--) plan.push_back(SYNC[i]);
                for (int k = 0; k < FLEN; k++) begin
                    v = 8'($urandom);
                    pay.push_back(v);
                    for (int i = 7; i >= 0; i--) plan.push_back(v[i]);
                end
            end while (!same_q(ref_frames(plan), pay));
            clear();
            for (int i = 0; i < plan.size(); i++) send_bit(plan[i]);
            send_bit(1'b1);
            send_bit(1'b1);
            cmp_frames($sformatf("rand%0d", r), ref_frames(sent));
        end

        // Stream offset by one sample: must slip in HUNT, then decode 3C cleanly.
        clear();
        err_pulses = 0;
        put(1'b0);
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        send_byte(SYNC);
        check("slip_locked", sync_ok, 1'b1);
        for (int k = 0; k < FLEN; k++) send_byte(8'h3C);
        send_bit(1'b1);
        send_bit(1'b1);
        exp.delete();
        for (int k = 0; k < FLEN; k++) exp.push_back(8'h3C);
        cmp_frames("slip", exp);
        check("slip_no_code_err", err_pulses, 0);

        // Code violation in DATA while a byte is held.
        clear();
        err_pulses = 0;
        data_ready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h5A);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        put(lvl);
        put(lvl);
        check("viol_code_err", code_err, 1'b1);
        check("viol_sync_drop", sync_ok, 1'b0);
        check("viol_data_held", data_out, 8'h5A);
        check("viol_valid_held", data_valid, 1'b1);
        send_bit(1'b1);
        check("viol_pulse_end", code_err, 1'b0);
        check("viol_one_pulse", err_pulses, 1);
        data_ready = 1'b1;
        send_bit(1'b1);
        exp.delete();
        exp.push_back(8'h5A);
        cmp_frames("viol", exp);
        check("viol_drained", data_valid, 1'b0);

        // Overrun: 11 held, 22 dropped, frame count still advances.
        clear();
        data_ready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovr_data_held", data_out, 8'h11);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_valid", data_valid, 1'b1);
        data_ready = 1'b1;
        exp.delete();
        exp.push_back(8'h11);
        for (int k = 3; k < FLEN; k++) begin
            send_byte(8'(8'h30 + k));
            exp.push_back(8'(8'h30 + k));
        end
        check("ovr_sync_before_last", sync_ok, 1'b1);
        send_byte(8'(8'h30 + FLEN));
        exp.push_back(8'(8'h30 + FLEN));
        check("ovr_frame_end", sync_ok, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        cmp_frames("ovr", exp);
        check("ovr_sticky", overrun, 1'b1);

        // Accept and new load on the same edge.
        clear();
        check("clear_overrun", overrun, 1'b0);
        data_ready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h66);
        v = 8'h99;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        put(lvl);
        lvl = ~lvl;
        data_ready = 1'b1;
        put(lvl);
        check("simul_valid", data_valid, 1'b1);
        check("simul_data", data_out, 8'h99);
        check("simul_no_overrun", overrun, 1'b0);
        send_bit(1'b1);
        exp.delete();
        exp.push_back(8'h66);
        exp.push_back(8'h99);
        cmp_frames("simul", exp);

        // Reset mid-payload, then a clear pulse, then re-lock.
        clear();
        data_ready = 1'b0;
        send_byte(SYNC);
        send_byte(8'h77);
        send_byte(8'h88);
        send_bit(1'b0); send_bit(1'b1);
        check("pre_rst_overrun", overrun, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk2x);
        #1;
        rst = 1'b0;
        lvl = 1'b0;
        data_ready = 1'b1;
        clear();
        check_reset_outputs("postclr");
        send_byte(SYNC);
        for (int k = 0; k < FLEN; k++) send_byte(8'($urandom));
        send_bit(1'b1);
        send_bit(1'b1);
        cmp_frames("relock", ref_frames(sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
